// File: rtl/pc_sequencer.sv
// Program counter with absolute load, relative branch, stepped increment, stall
// and a circular return-address stack for call/return.
module pc_sequencer #(
    parameter int                      DATA_WIDTH_IN  = 32,
    parameter int                      DATA_WIDTH_OUT = 32,
    parameter logic [DATA_WIDTH_IN-1:0] INIT          = '0,
    parameter int                      STEP           = 1,
    parameter int                      OFFSET_WIDTH   = 16,
    parameter int                      RAS_DEPTH      = 4
) (
    input  logic                      clock,
    input  logic                      clear,
    input  logic                      stall,
    input  logic                      enable,
    input  logic                      IncPC,
    input  logic                      branch,
    input  logic [OFFSET_WIDTH-1:0]   offset,
    input  logic                      call,
    input  logic                      ret,
    input  logic                      flag_clr,
    input  logic [DATA_WIDTH_IN-1:0]  BusMuxOut,
    output logic [DATA_WIDTH_OUT-1:0] BusMuxIn,
    output logic                      ras_empty,
    output logic                      ras_full,
    output logic                      ras_overflow,
    output logic                      ras_underflow
);

    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam logic [PW-1:0]            PTR_LAST = PW'(RAS_DEPTH - 1);
    localparam logic [CW-1:0]            CNT_FULL = CW'(RAS_DEPTH);
    localparam logic [DATA_WIDTH_IN-1:0] STEP_V   = DATA_WIDTH_IN'(STEP);

    logic [DATA_WIDTH_IN-1:0] q_reg;
    logic [DATA_WIDTH_IN-1:0] ras_reg [RAS_DEPTH];
    logic [PW-1:0]            wr_ptr_reg;
    logic [CW-1:0]            count_reg;
    logic                     ovf_reg;
    logic                     unf_reg;

    logic [PW-1:0]            ptr_inc;
    logic [PW-1:0]            ptr_dec;
    logic [DATA_WIDTH_IN-1:0] offset_ext;

    // wr_ptr_reg names the next free slot; when full it is also the oldest entry,
    // so a push while full naturally overwrites the oldest address.
    assign ptr_inc    = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PW'(1);
    assign ptr_dec    = (wr_ptr_reg == '0) ? PTR_LAST : wr_ptr_reg - PW'(1);
    assign offset_ext = DATA_WIDTH_IN'($signed(offset));

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            q_reg      <= INIT;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
            unf_reg    <= 1'b0;
            for (int k = 0; k < RAS_DEPTH; k++) begin
                ras_reg[k] <= '0;
            end
        end else if (!stall) begin
            // Clear first so that a setting event later in this block wins.
            if (flag_clr) begin
                ovf_reg <= 1'b0;
                unf_reg <= 1'b0;
            end
            if (ret) begin
                if (count_reg != '0) begin
                    q_reg      <= ras_reg[ptr_dec];
                    wr_ptr_reg <= ptr_dec;
                    count_reg  <= count_reg - CW'(1);
                end else begin
                    unf_reg <= 1'b1;
                end
            end else if (call) begin
                ras_reg[wr_ptr_reg] <= q_reg + STEP_V;
                q_reg               <= BusMuxOut;
                wr_ptr_reg          <= ptr_inc;
                if (count_reg == CNT_FULL) begin
                    ovf_reg <= 1'b1;
                end else begin
                    count_reg <= count_reg + CW'(1);
                end
            end else if (enable) begin
                q_reg <= BusMuxOut;
            end else if (branch) begin
                q_reg <= q_reg + offset_ext;
            end else if (IncPC) begin
                q_reg <= q_reg + STEP_V;
            end
        end
    end

    assign BusMuxIn      = q_reg[DATA_WIDTH_OUT-1:0];
    assign ras_empty     = (count_reg == '0);
    assign ras_full      = (count_reg == CNT_FULL);
    assign ras_overflow  = ovf_reg;
    assign ras_underflow = unf_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized checks of pc_sequencer against a queue-based
// reference model of the program counter and return-address stack.
module tb_pc_sequencer;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        stall = 1'b0;
    logic        enable = 1'b0;
    logic        IncPC = 1'b0;
    logic        branch = 1'b0;
    logic [15:0] offset = '0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic        flag_clr = 1'b0;
    logic [31:0] BusMuxOut = '0;
    logic [31:0] BusMuxIn;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_overflow;
    logic        ras_underflow;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: PC value, LIFO of return addresses (oldest at front), flags.
    logic [31:0] m_q = '0;
    logic [31:0] m_ras [$];
    bit          m_ovf = 1'b0;
    bit          m_unf = 1'b0;

    pc_sequencer dut (
        .clock(clock), .clear(clear), .stall(stall), .enable(enable),
        .IncPC(IncPC), .branch(branch), .offset(offset), .call(call),
        .ret(ret), .flag_clr(flag_clr), .BusMuxOut(BusMuxOut),
        .BusMuxIn(BusMuxIn), .ras_empty(ras_empty), .ras_full(ras_full),
        .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
    );

    always #5 clock = ~clock;

    task automatic model_step();
        if (!clear) begin
            m_q = '0;
            m_ras.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (!stall) begin
            if (flag_clr) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
            if (ret) begin
                if (m_ras.size() > 0) m_q = m_ras.pop_back();
                else m_unf = 1'b1;
            end else if (call) begin
                if (m_ras.size() == DEPTH) begin
                    void'(m_ras.pop_front());
                    m_ovf = 1'b1;
                end
                m_ras.push_back(m_q + 32'd1);
                m_q = BusMuxOut;
            end else if (enable) begin
                m_q = BusMuxOut;
            end else if (branch) begin
                m_q = m_q + {{16{offset[15]}}, offset};
            end else if (IncPC) begin
                m_q = m_q + 32'd1;
            end
        end
    endtask

    // Drive one cycle of controls, advance the model on the edge, sample 1 after.
    task automatic cycle(input bit s, input bit r, input bit c, input bit e,
                         input bit b, input bit i, input bit fc,
                         input logic [31:0] bv, input logic [15:0] ov);
        stall = s; ret = r; call = c; enable = e; branch = b; IncPC = i;
        flag_clr = fc; BusMuxOut = bv; offset = ov;
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        clear = 1'b0;
        cycle(0, 0, 1, 1, 0, 1, 0, 32'hDEAD_BEEF, 16'h0);
        cycle(0, 0, 0, 0, 0, 0, 0, 32'h0, 16'h0);
        vectors++;
        if ({BusMuxIn, ras_empty, ras_full, ras_overflow, ras_underflow} !== {32'h0, 4'b1000}) begin
            miscompares++;
            $display("FAIL reset: got pc=%h e=%b f=%b o=%b u=%b, want pc=0 e=1 f=0 o=0 u=0",
                     BusMuxIn, ras_empty, ras_full, ras_overflow, ras_underflow);
        end
        clear = 1'b1;
    endtask

    task automatic test_priority();
        cycle(0, 0, 0, 1, 0, 1, 0, 32'h100, 16'h0);
        vectors++;
        if (BusMuxIn !== 32'h100) begin
            miscompares++;
            $display("FAIL enable_over_inc: got %h want 00000100", BusMuxIn);
        end
        cycle(0, 0, 0, 0, 0, 1, 0, 32'h0, 16'h0);
        vectors++;
        if (BusMuxIn !== 32'h101) begin
            miscompares++;
            $display("FAIL incpc: got %h want 00000101", BusMuxIn);
        end
        cycle(0, 0, 0, 1, 1, 1, 0, 32'h77, 16'h0010);
        vectors++;
        if (BusMuxIn !== 32'h77) begin
            miscompares++;
            $display("FAIL enable_over_branch: got %h want 00000077", BusMuxIn);
        end
        cycle(0, 0, 0, 0, 1, 1, 0, 32'h0, 16'h0010);
        vectors++;
        if (BusMuxIn !== 32'h87) begin
            miscompares++;
            $display("FAIL branch_over_inc: got %h want 00000087", BusMuxIn);
        end
    endtask

    task automatic test_branch_wrap();
        cycle(0, 0, 0, 1, 0, 0, 0, 32'h10, 16'h0);
        cycle(0, 0, 0, 0, 1, 0, 0, 32'h0, 16'hFFF0);
        vectors++;
        if (BusMuxIn !== 32'h0) begin
            miscompares++;
            $display("FAIL branch_neg16: got %h want 00000000", BusMuxIn);
        end
        cycle(0, 0, 0, 0, 1, 0, 0, 32'h0, 16'hFFFF);
        vectors++;
        if (BusMuxIn !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL branch_wrap: got %h want ffffffff", BusMuxIn);
        end
        cycle(0, 0, 0, 0, 0, 1, 0, 32'h0, 16'h0);
        vectors++;
        if (BusMuxIn !== 32'h0) begin
            miscompares++;
            $display("FAIL inc_wrap: got %h want 00000000", BusMuxIn);
        end
    endtask

    task automatic test_call_return();
        logic [31:0] want [4] = '{32'h81, 32'h61, 32'h41, 32'h21};
        cycle(0, 0, 0, 1, 0, 0, 0, 32'h20, 16'h0);
        for (int k = 0; k < 4; k++) begin
            cycle(0, 0, 1, 0, 0, 0, 0, 32'h40 + 32'(k) * 32'h20, 16'h0);
        end
        vectors++;
        if ({BusMuxIn, ras_empty, ras_full} !== {32'hA0, 2'b01}) begin
            miscompares++;
            $display("FAIL calls_full: got pc=%h e=%b f=%b want pc=000000a0 e=0 f=1",
                     BusMuxIn, ras_empty, ras_full);
        end
        for (int k = 0; k < 4; k++) begin
            cycle(0, 1, 0, 0, 0, 0, 0, 32'h0, 16'h0);
            vectors++;
            if (BusMuxIn !== want[k]) begin
                miscompares++;
                $display("FAIL ret%0d: got %h want %h", k, BusMuxIn, want[k]);
            end
        end
        vectors++;
        if ({ras_empty, ras_full, ras_overflow, ras_underflow} !== 4'b1000) begin
            miscompares++;
            $display("FAIL ret_status: got e=%b f=%b o=%b u=%b want e=1 f=0 o=0 u=0",
                     ras_empty, ras_full, ras_overflow, ras_underflow);
        end
    endtask

    task automatic test_overflow_underflow();
        logic [31:0] want [4] = '{32'hA1, 32'h81, 32'h61, 32'h41};
        cycle(0, 0, 0, 1, 0, 0, 0, 32'h20, 16'h0);
        for (int k = 0; k < 5; k++) begin
            cycle(0, 0, 1, 0, 0, 0, 0, 32'h40 + 32'(k) * 32'h20, 16'h0);
        end
        vectors++;
        if ({BusMuxIn, ras_full, ras_overflow} !== {32'hC0, 2'b11}) begin
            miscompares++;
            $display("FAIL overflow: got pc=%h f=%b o=%b want pc=000000c0 f=1 o=1",
                     BusMuxIn, ras_full, ras_overflow);
        end
        for (int k = 0; k < 4; k++) begin
            cycle(0, 1, 0, 0, 0, 0, 0, 32'h0, 16'h0);
            vectors++;
            if (BusMuxIn !== want[k]) begin
                miscompares++;
                $display("FAIL ovf_ret%0d: got %h want %h", k, BusMuxIn, want[k]);
            end
        end
        cycle(0, 1, 0, 0, 0, 0, 0, 32'h0, 16'h0);
        vectors++;
        if ({BusMuxIn, ras_empty, ras_overflow, ras_underflow} !== {32'h41, 3'b111}) begin
            miscompares++;
            $display("FAIL underflow: got pc=%h e=%b o=%b u=%b want pc=00000041 e=1 o=1 u=1",
                     BusMuxIn, ras_empty, ras_overflow, ras_underflow);
        end
        // Set beats clear when they coincide.
        cycle(0, 1, 0, 0, 0, 0, 1, 32'h0, 16'h0);
        vectors++;
        if ({ras_overflow, ras_underflow} !== 2'b01) begin
            miscompares++;
            $display("FAIL set_wins: got o=%b u=%b want o=0 u=1", ras_overflow, ras_underflow);
        end
        cycle(0, 0, 0, 0, 0, 0, 1, 32'h0, 16'h0);
        vectors++;
        if ({ras_overflow, ras_underflow} !== 2'b00) begin
            miscompares++;
            $display("FAIL flag_clr: got o=%b u=%b want o=0 u=0", ras_overflow, ras_underflow);
        end
    endtask

    task automatic test_stall();
        cycle(0, 0, 0, 1, 0, 0, 0, 32'h300, 16'h0);
        cycle(0, 0, 1, 0, 0, 0, 0, 32'h400, 16'h0);
        cycle(0, 1, 0, 0, 0, 0, 0, 32'h0, 16'h0);
        cycle(0, 1, 0, 0, 0, 0, 0, 32'h0, 16'h0);
        for (int k = 0; k < 3; k++) begin
            cycle(1, 1, 1, 1, 1, 1, 1, 32'h999, 16'h0004);
            vectors++;
            if ({BusMuxIn, ras_empty, ras_full, ras_overflow, ras_underflow} !== {32'h301, 4'b1001}) begin
                miscompares++;
                $display("FAIL stall%0d: got pc=%h e=%b f=%b o=%b u=%b want pc=00000301 e=1 f=0 o=0 u=1",
                         k, BusMuxIn, ras_empty, ras_full, ras_overflow, ras_underflow);
            end
        end
    endtask

    task automatic test_random();
        bit s, r, c, e, b, i, fc;
        for (int n = 0; n < 400; n++) begin
            s  = ($urandom_range(9) == 0);
            r  = ($urandom_range(3) == 0);
            c  = ($urandom_range(3) == 0);
            e  = ($urandom_range(4) == 0);
            b  = ($urandom_range(3) == 0);
            i  = ($urandom_range(1) == 0);
            fc = ($urandom_range(11) == 0);
            cycle(s, r, c, e, b, i, fc, $urandom, 16'($urandom));
            vectors++;
            if ({BusMuxIn, ras_empty, ras_full, ras_overflow, ras_underflow} !==
                {m_q, m_ras.size() == 0, m_ras.size() == DEPTH, m_ovf, m_unf}) begin
                miscompares++;
                $display("FAIL random%0d: got pc=%h e=%b f=%b o=%b u=%b want pc=%h e=%b f=%b o=%b u=%b",
                         n, BusMuxIn, ras_empty, ras_full, ras_overflow, ras_underflow,
                         m_q, m_ras.size() == 0, m_ras.size() == DEPTH, m_ovf, m_unf);
            end
        end
    endtask

    task automatic test_async_reset();
        cycle(0, 0, 1, 0, 0, 0, 0, 32'h1234, 16'h0);
        cycle(0, 0, 1, 0, 0, 0, 0, 32'h5678, 16'h0);
        cycle(0, 1, 0, 0, 0, 0, 0, 32'h0, 16'h0);
        cycle(0, 1, 0, 0, 0, 0, 0, 32'h0, 16'h0);
        cycle(0, 1, 0, 0, 0, 0, 0, 32'h0, 16'h0);
        call = 1'b1;
        BusMuxOut = 32'h500;
        #2;
        clear = 1'b0;
        #1;
        vectors++;
        if ({BusMuxIn, ras_empty, ras_full, ras_overflow, ras_underflow} !== {32'h0, 4'b1000}) begin
            miscompares++;
            $display("FAIL async_reset: got pc=%h e=%b f=%b o=%b u=%b want pc=0 e=1 f=0 o=0 u=0",
                     BusMuxIn, ras_empty, ras_full, ras_overflow, ras_underflow);
        end
        @(posedge clock);
        model_step();
        #1;
        vectors++;
        if ({BusMuxIn, ras_empty} !== {32'h0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_hold: got pc=%h e=%b want pc=0 e=1", BusMuxIn, ras_empty);
        end
        clear = 1'b1;
        cycle(0, 1, 0, 0, 0, 0, 0, 32'h0, 16'h0);
        vectors++;
        if ({BusMuxIn, ras_empty, ras_underflow} !== {32'h0, 2'b11}) begin
            miscompares++;
            $display("FAIL no_partial_push: got pc=%h e=%b u=%b want pc=0 e=1 u=1",
                     BusMuxIn, ras_empty, ras_underflow);
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_branch_wrap();
        test_call_return();
        test_overflow_underflow();
        test_stall();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
